// File: rtl/seg_serial_ctrl.sv
// Serial 7-segment chain driver: captures a frame, shifts it MSB-first on a divided clock,
// blanks the display while shifting and coalesces mid-frame refresh requests into one.
module seg_serial_ctrl #(
  parameter int WIDTH = 64,
  parameter int HALF  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seg_data,
  output logic             seg_clk,
  output logic             seg_sout,
  output logic             seg_pen,
  output logic             seg_clrn,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             seg_clk_q, seg_clk_d;
  logic             seg_sout_q, seg_sout_d;
  logic             seg_pen_q, seg_pen_d;
  logic             seg_clrn_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             capture, shift;
  logic             phase_end, last_bit;

  assign phase_end = (ph_q == PW'(HALF - 1));
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      pend_q     <= 1'b0;
      seg_clk_q  <= 1'b0;
      seg_sout_q <= 1'b0;
      seg_pen_q  <= 1'b0;
      seg_clrn_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
      seg_clk_q  <= seg_clk_d;
      seg_sout_q <= seg_sout_d;
      seg_pen_q  <= seg_pen_d;
      seg_clrn_q <= 1'b1;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    capture  = 1'b0;
    shift    = 1'b0;
    case (state_q)
      IDLE: capture = start;
      LOW: begin
        pend_d = pend_q | start;
        if (phase_end) begin
          state_d = HIGH;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      HIGH: begin
        pend_d = pend_q | start;
        if (phase_end) begin
          ph_d = '0;
          if (last_bit) begin
            state_d = DONE;
          end else begin
            shift   = 1'b1;
            cnt_d   = cnt_q + CW'(1);
            state_d = LOW;
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      DONE: begin
        if (pend_q || start) begin
          capture = 1'b1;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Shadow shifts left so the next bit to send always sits just below the MSB.
    if (capture) begin
      state_d  = LOW;
      ph_d     = '0;
      cnt_d    = '0;
      shadow_d = seg_data;
    end else if (shift) begin
      shadow_d = shadow_q << 1;
    end
  end

  always_comb begin
    seg_clk_d = (state_d == HIGH);
    busy_d    = (state_d == LOW) || (state_d == HIGH);
    done_d    = (state_d == DONE);
    seg_pen_d = seg_pen_q;
    if (state_d == DONE)
      seg_pen_d = 1'b1;
    else if (busy_d)
      seg_pen_d = 1'b0;
    seg_sout_d = seg_sout_q;
    if (capture)
      seg_sout_d = seg_data[WIDTH-1];
    else if (shift)
      seg_sout_d = shadow_q[WIDTH-2];
    else if (state_d == DONE)
      seg_sout_d = 1'b0;
  end

  assign seg_clk  = seg_clk_q;
  assign seg_sout = seg_sout_q;
  assign seg_pen  = seg_pen_q;
  assign seg_clrn = seg_clrn_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
